// File: rtl/msd_pkg.sv
// Shared constants and helpers for the multi-channel strobe divider.
package msd_pkg;

  localparam int unsigned MSD_DEF_DIV = 52;

  // Channel-select width, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/strobe_channel.sv
// One divider channel: counter, ratio/phase shadow registers and strobe register.
// All outputs are registered; shadow writes become visible one cycle after the write.
module strobe_channel
  import msd_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned DEF_DIV = MSD_DEF_DIV
) (
  input  logic         in_clk,
  input  logic         rst,
  input  logic         wr_i,
  input  logic [W-1:0] wr_div_i,
  input  logic [W-1:0] wr_phase_i,
  input  logic         en_i,
  input  logic         sync_i,
  output logic         stb_o,
  output logic [W-1:0] cnt_o,
  output logic         pend_o
);

  localparam logic [W-1:0] DIV_RST = W'(DEF_DIV);
  localparam logic [W-1:0] ONE     = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_act_q, div_act_d;
  logic [W-1:0] div_sh_q, div_sh_d;
  logic [W-1:0] ph_sh_q, ph_sh_d;
  logic         pend_q, pend_d;
  logic         stb_q, stb_d;

  logic [W-1:0] div_in;
  logic [W-1:0] div_src;
  logic [W-1:0] ph_src;

  always_comb begin
    div_in    = (wr_div_i == '0) ? ONE : wr_div_i;
    // A write in the same cycle as sync must be seen by the sync.
    div_src   = wr_i ? div_in : div_sh_q;
    ph_src    = wr_i ? wr_phase_i : ph_sh_q;

    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_sh_d  = div_sh_q;
    ph_sh_d   = ph_sh_q;
    pend_d    = pend_q;
    stb_d     = 1'b0;

    if (sync_i) begin
      div_act_d = div_src;
      pend_d    = 1'b0;
      cnt_d     = (ph_src > (div_src - ONE)) ? (div_src - ONE) : ph_src;
    end else if (en_i) begin
      if (cnt_q == (div_act_q - ONE)) begin
        cnt_d = '0;
        stb_d = 1'b1;
        if (pend_q) begin
          div_act_d = div_sh_q;
          pend_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end

    if (wr_i) begin
      div_sh_d = div_in;
      ph_sh_d  = wr_phase_i;
      pend_d   = ~sync_i;
    end
  end

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      div_act_q <= DIV_RST;
      div_sh_q  <= DIV_RST;
      ph_sh_q   <= '0;
      pend_q    <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_sh_q  <= div_sh_d;
      ph_sh_q   <= ph_sh_d;
      pend_q    <= pend_d;
      stb_q     <= stb_d;
    end
  end

  assign stb_o  = stb_q;
  assign cnt_o  = cnt_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/multi_strobe_divider.sv
// CH independent programmable clock-enable dividers with shared load bus and global sync.
// Outputs are registered; no input-to-output combinational path.
module multi_strobe_divider
  import msd_pkg::*;
#(
  parameter int unsigned CH      = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned DEF_DIV = MSD_DEF_DIV
) (
  input  logic                    in_clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [sel_width(CH)-1:0] load_ch,
  input  logic [W-1:0]            load_div,
  input  logic [W-1:0]            load_phase,
  input  logic [CH-1:0]           ch_en,
  input  logic                    sync,
  output logic [CH-1:0]           out_stb,
  output logic [CH*W-1:0]         phase_idx,
  output logic [CH-1:0]           pending
);

  localparam int unsigned SEL_W = sel_width(CH);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic wr;

    // Selects >= CH match no channel and are dropped.
    assign wr = load && (load_ch == SEL_W'(i));

    strobe_channel #(
      .W       (W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .in_clk     (in_clk),
      .rst        (rst),
      .wr_i       (wr),
      .wr_div_i   (load_div),
      .wr_phase_i (load_phase),
      .en_i       (ch_en[i]),
      .sync_i     (sync),
      .stb_o      (out_stb[i]),
      .cnt_o      (phase_idx[i*W +: W]),
      .pend_o     (pending[i])
    );
  end

endmodule
